// File: rtl/color_freq_sampler.sv
// Colour sensor front end: steps S2/S3 through red/green/blue/clear, counts sensor edges per
// gate window and presents a frame over valid/ack. Define COLOR_SAMPLER_OVF_EN to add ovf.
module color_freq_sampler #(
    parameter int unsigned GATE_CYCLES   = 100000,
    parameter int unsigned SETTLE_CYCLES = 5000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_out,
    input  logic             enable,
    input  logic             sample_ack,
    output logic [1:0]       filter_sel,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             sample_valid,
`ifdef COLOR_SAMPLER_OVF_EN
    output logic [3:0]       ovf,
`endif
    output logic             busy
);

    localparam int unsigned MAX_T = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [TW-1:0] SETTLE_LAST =
        TW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST =
        TW'((GATE_CYCLES == 0) ? 0 : GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCount,
        StStore,
        StPresent
    } state_t;

    state_t           state;
    logic             sync1, sync2, sync3;
    logic             sensor_edge;
    logic [1:0]       idx;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] shadow [4];
    logic             abort;

    // Filter index to {S2,S3}: red, green, blue, clear.
    function automatic logic [1:0] sel_code(input logic [1:0] i);
        case (i)
            2'd0:    sel_code = 2'b00;
            2'd1:    sel_code = 2'b11;
            2'd2:    sel_code = 2'b01;
            default: sel_code = 2'b10;
        endcase
    endfunction

    assign sensor_edge = sync2 & ~sync3;
    assign abort       = !enable && (state == StSettle || state == StCount);

    always_comb begin
        cnt_next = cnt;
        if (sensor_edge && (cnt != {CNT_W{1'b1}})) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync3        <= 1'b0;
            state        <= StIdle;
            idx          <= 2'd0;
            timer        <= '0;
            cnt          <= '0;
            shadow[0]    <= '0;
            shadow[1]    <= '0;
            shadow[2]    <= '0;
            shadow[3]    <= '0;
            filter_sel   <= 2'b00;
            red_cnt      <= '0;
            green_cnt    <= '0;
            blue_cnt     <= '0;
            clear_cnt    <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef COLOR_SAMPLER_OVF_EN
            ovf          <= 4'b0000;
`endif
        end else begin
            sync1 <= sensor_out;
            sync2 <= sync1;
            sync3 <= sync2;

            if (abort) begin
                // Partial frame is discarded; the last presented frame stays on the outputs.
                state      <= StIdle;
                busy       <= 1'b0;
                filter_sel <= 2'b00;
                idx        <= 2'd0;
                timer      <= '0;
                cnt        <= '0;
                shadow[0]  <= '0;
                shadow[1]  <= '0;
                shadow[2]  <= '0;
                shadow[3]  <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        filter_sel <= 2'b00;
                        if (enable) begin
                            state <= StSettle;
                            busy  <= 1'b1;
                            idx   <= 2'd0;
                            timer <= '0;
                            cnt   <= '0;
                        end
                    end

                    StSettle: begin
                        if (timer == SETTLE_LAST) begin
                            state <= StCount;
                            timer <= '0;
                            cnt   <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    StCount: begin
                        if (timer == GATE_LAST) begin
                            // The final window cycle's edge is folded in via cnt_next.
                            shadow[idx] <= cnt_next;
                            cnt         <= '0;
                            timer       <= '0;
                            idx         <= idx + 2'd1;
                            if (idx == 2'd3) begin
                                state      <= StStore;
                                filter_sel <= 2'b00;
                            end else begin
                                state      <= StSettle;
                                filter_sel <= sel_code(idx + 2'd1);
                            end
                        end else begin
                            cnt   <= cnt_next;
                            timer <= timer + TW'(1);
                        end
                    end

                    StStore: begin
                        red_cnt      <= shadow[0];
                        green_cnt    <= shadow[1];
                        blue_cnt     <= shadow[2];
                        clear_cnt    <= shadow[3];
`ifdef COLOR_SAMPLER_OVF_EN
                        // Counts are monotonic, so an all-ones shadow means it saturated.
                        ovf          <= {&shadow[3], &shadow[2], &shadow[1], &shadow[0]};
`endif
                        sample_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= StPresent;
                    end

                    StPresent: begin
                        if (sample_ack) begin
                            sample_valid <= 1'b0;
                            if (enable) begin
                                state      <= StSettle;
                                busy       <= 1'b1;
                                filter_sel <= 2'b00;
                                idx        <= 2'd0;
                                timer      <= '0;
                                cnt        <= '0;
                            end else begin
                                state <= StIdle;
                            end
                        end
                    end

                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_color_freq_sampler.sv
// Directed bench for color_freq_sampler: frame capture vectors, handshake, abort, reset,
// settle masking and saturation (second instance with a 5-bit counter).
module tb_color_freq_sampler;

    localparam int unsigned GATE   = 100;
    localparam int unsigned SETTLE = 10;
    localparam int unsigned LAT    = 4 * (SETTLE + GATE) + 1;

    logic       clk;
    logic       rst;
    logic       sensor_out;
    logic       enable;
    logic       sample_ack;
    logic [1:0] filter_sel;
    logic [7:0] red_cnt, green_cnt, blue_cnt, clear_cnt;
    logic       sample_valid;
    logic       busy;

    logic       sensor2, enable2, ack2;
    logic [1:0] filter_sel2;
    logic [4:0] red2, green2, blue2, clear2;
    logic       valid2, busy2;
`ifdef COLOR_SAMPLER_OVF_EN
    logic [3:0] ovf, ovf2;
`endif

    logic       gen_mode, gen_val, man_val;
    int         periods [4];
    logic [1:0] codes [4];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int per [4];
        int exp [4];
        int tol;
    } vec_t;
    vec_t vecs [4];

    assign sensor_out = gen_mode ? gen_val : man_val;

    color_freq_sampler #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sensor_out(sensor_out), .enable(enable),
        .sample_ack(sample_ack), .filter_sel(filter_sel),
        .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt), .clear_cnt(clear_cnt),
        .sample_valid(sample_valid),
`ifdef COLOR_SAMPLER_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    color_freq_sampler #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(5)) dut_sat (
        .clk(clk), .rst(rst), .sensor_out(sensor2), .enable(enable2),
        .sample_ack(ack2), .filter_sel(filter_sel2),
        .red_cnt(red2), .green_cnt(green2), .blue_cnt(blue2), .clear_cnt(clear2),
        .sample_valid(valid2),
`ifdef COLOR_SAMPLER_OVF_EN
        .ovf(ovf2),
`endif
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sel_idx(input logic [1:0] s);
        case (s)
            2'b00:   sel_idx = 0;
            2'b11:   sel_idx = 1;
            2'b01:   sel_idx = 2;
            default: sel_idx = 3;
        endcase
    endfunction

    // Sensor model: square wave whose period follows the selected filter.
    initial begin
        int ph;
        int p;
        gen_val = 1'b0;
        ph = 0;
        forever begin
            @(negedge clk);
            p = periods[sel_idx(filter_sel)];
            if (p == 0) begin
                gen_val = 1'b0;
                ph = 0;
            end else begin
                if (ph >= p - 1) ph = 0;
                else ph++;
                gen_val = (ph < p / 2);
            end
        end
    end

    initial begin
        sensor2 = 1'b0;
        forever begin
            @(negedge clk);
            sensor2 = ~sensor2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_vec(input int i, input int p0, input int p1, input int p2, input int p3,
                           input int e0, input int e1, input int e2, input int e3,
                           input int tol);
        vecs[i].per[0] = p0; vecs[i].per[1] = p1; vecs[i].per[2] = p2; vecs[i].per[3] = p3;
        vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2; vecs[i].exp[3] = e3;
        vecs[i].tol = tol;
    endtask

    // Starts a frame from IDLE, tracks filter_sel each cycle and checks latency and counts.
    task automatic run_frame(input int v);
        int k;
        int sel_err;
        int lo;
        logic [1:0] exp_sel;
        for (int f = 0; f < 4; f++) periods[f] = vecs[v].per[f];
        gen_mode = 1'b1;
        k = 0;
        sel_err = 0;
        @(negedge clk);
        enable = 1'b1;
        while (k < 700) begin
            @(posedge clk);
            #1;
            k++;
            if (sample_valid) break;
            exp_sel = (k - 1 < 440) ? codes[(k - 1) / 110] : 2'b00;
            if (filter_sel !== exp_sel) sel_err++;
        end
        check($sformatf("v%0d_latency", v), k - 1, LAT);
        check($sformatf("v%0d_sel_seq_errs", v), sel_err, 0);
        lo = (vecs[v].exp[0] > vecs[v].tol) ? vecs[v].exp[0] - vecs[v].tol : 0;
        check_rng($sformatf("v%0d_red", v), int'(red_cnt), lo, vecs[v].exp[0] + vecs[v].tol);
        lo = (vecs[v].exp[1] > vecs[v].tol) ? vecs[v].exp[1] - vecs[v].tol : 0;
        check_rng($sformatf("v%0d_green", v), int'(green_cnt), lo, vecs[v].exp[1] + vecs[v].tol);
        lo = (vecs[v].exp[2] > vecs[v].tol) ? vecs[v].exp[2] - vecs[v].tol : 0;
        check_rng($sformatf("v%0d_blue", v), int'(blue_cnt), lo, vecs[v].exp[2] + vecs[v].tol);
        lo = (vecs[v].exp[3] > vecs[v].tol) ? vecs[v].exp[3] - vecs[v].tol : 0;
        check_rng($sformatf("v%0d_clear", v), int'(clear_cnt), lo, vecs[v].exp[3] + vecs[v].tol);
`ifdef COLOR_SAMPLER_OVF_EN
        check($sformatf("v%0d_ovf", v), ovf, 0);
`endif
    endtask

    task automatic ack_frame(input logic en);
        @(negedge clk);
        enable = en;
        sample_ack = 1'b1;
        @(posedge clk);
        #1;
        sample_ack = 1'b0;
        check("ack_valid_low", sample_valid, 1'b0);
        check("ack_busy", busy, en);
        check("ack_sel_red", filter_sel, 2'b00);
    endtask

    initial begin
        logic [7:0] sv_r, sv_g, sv_b, sv_c;
        logic [1:0] sv_sel;
        int err;
        int k;

        codes[0] = 2'b00; codes[1] = 2'b11; codes[2] = 2'b01; codes[3] = 2'b10;
        set_vec(0, 10, 20, 25, 5,  10, 5, 4, 20,  1);
        set_vec(1, 4, 10, 50, 20,  25, 10, 2, 5,  1);
        set_vec(2, 0, 0, 0, 0,     0, 0, 0, 0,    0);
        set_vec(3, 2, 3, 100, 8,   50, 33, 1, 12, 1);
        for (int f = 0; f < 4; f++) periods[f] = 0;

        rst = 1'b1;
        enable = 1'b0;
        sample_ack = 1'b0;
        enable2 = 1'b0;
        ack2 = 1'b0;
        gen_mode = 1'b1;
        man_val = 1'b0;
        #12;
        check("rst_sel", filter_sel, 2'b00);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_counts", {red_cnt, green_cnt, blue_cnt, clear_cnt}, 32'd0);
        #11;
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_frame(v);
            ack_frame(1'b0);
        end

        // Handshake hold: frame must stay put while ack is low.
        run_frame(0);
        sv_r = red_cnt; sv_g = green_cnt; sv_b = blue_cnt; sv_c = clear_cnt;
        sv_sel = filter_sel;
        err = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (!sample_valid || red_cnt !== sv_r || green_cnt !== sv_g ||
                blue_cnt !== sv_b || clear_cnt !== sv_c || filter_sel !== sv_sel || busy)
                err++;
        end
        check("hold_stable_errs", err, 0);
        ack_frame(1'b1);

        // Abort in green COUNT.
        repeat (110) @(posedge clk);
        #1;
        check("restart_green_sel", filter_sel, 2'b11);
        repeat (40) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_sel", filter_sel, 2'b00);
        check("abort_valid", sample_valid, 1'b0);
        check("abort_keep_cnts", {red_cnt, green_cnt, blue_cnt, clear_cnt},
              {sv_r, sv_g, sv_b, sv_c});
        repeat (20) @(posedge clk);
        #1;
        check("abort_stays_idle", {busy, sample_valid}, 2'b00);
        run_frame(1);

        // Asynchronous reset mid-frame, between clock edges.
        ack_frame(1'b1);
        repeat (150) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sel", filter_sel, 2'b00);
        check("arst_busy", busy, 1'b0);
        check("arst_valid", sample_valid, 1'b0);
        check("arst_counts", {red_cnt, green_cnt, blue_cnt, clear_cnt}, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Settle masking: pulses only in the first cycles of each SETTLE window.
        gen_mode = 1'b0;
        man_val = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 110; c++) begin
                @(negedge clk);
                man_val = (c == 1 || c == 3 || c == 5);
            end
        end
        k = 0;
        while (!sample_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("mask_valid", sample_valid, 1'b1);
        check("mask_counts", {red_cnt, green_cnt, blue_cnt, clear_cnt}, 32'd0);
        ack_frame(1'b0);

        // Saturation on the 5-bit instance with a 2-cycle sensor period.
        @(negedge clk);
        enable2 = 1'b1;
        k = 0;
        while (k < 700) begin
            @(posedge clk);
            #1;
            k++;
            if (valid2) break;
        end
        check("sat_latency", k - 1, LAT);
        check("sat_counts", {red2, green2, blue2, clear2}, {4{5'd31}});
        check("sat_sel", filter_sel2, 2'b00);
`ifdef COLOR_SAMPLER_OVF_EN
        check("sat_ovf", ovf2, 4'b1111);
`endif
        check("sat_busy", busy2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
